chunk_serial_adder: RTL and testbench



---
 rtl/chunk_serial_adder.sv | 103 ++++++++++
 tb/tb_chunk_serial_adder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, with a registered carry between slices.
// Handshake is start/busy/done. Results update only on the edge that completes an operation.
module chunk_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_b_q, res_q, res_next;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic             accept, last;
  logic [CHUNK:0]   slice;
  logic             slice_ovf;

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        accept  = 1'b1;
        state_d = RUN;
      end
      RUN:  if (last) state_d = DONE;
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign last = (idx_q == LAST);

  // Operands shift right each RUN cycle, so the active slice is always the low CHUNK bits.
  assign slice = {1'b0, op_a_q[CHUNK-1:0]} + {1'b0, op_b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};

  // The carry into the slice MSB is recovered as sum ^ a ^ b at that bit.
  assign slice_ovf = slice[CHUNK] ^ slice[CHUNK-1] ^ op_a_q[CHUNK-1] ^ op_b_q[CHUNK-1];

  assign res_next = (res_q >> CHUNK) | (WIDTH'(slice[CHUNK-1:0]) << (WIDTH - CHUNK));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_a_q  <= a;
        op_b_q  <= sub ? ~b : b;
        carry_q <= sub | cin;
        idx_q   <= '0;
      end else if (state_q == RUN) begin
        op_a_q  <= op_a_q >> CHUNK;
        op_b_q  <= op_b_q >> CHUNK;
        res_q   <= res_next;
        carry_q <= slice[CHUNK];
        idx_q   <= idx_q + IW'(1);
        if (last) begin
          sum  <= res_next;
          cout <= slice[CHUNK];
          ovf  <= slice_ovf;
        end
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Self-checking bench for chunk_serial_adder in three configurations: 16/4, 16/16 and 32/8.
// It runs directed handshake and boundary steps, then random operations against an arithmetic model.
module tb_chunk_serial_adder;
  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [31:0] sum;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start_v = '0;
  logic [31:0] a_in = '0, b_in = '0;
  logic        cin_in = 1'b0, sub_in = 1'b0;

  logic        busy0, done0, cout0, ovf0;
  logic [15:0] sum0;
  logic        busy1, done1, cout1, ovf1;
  logic [15:0] sum1;
  logic        busy2, done2, cout2, ovf2;
  logic [31:0] sum2;

  int          cur = 0;
  logic        busy_m, done_m, cout_m, ovf_m;
  logic [31:0] sum_m;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_in[15:0]), .b(b_in[15:0]),
    .cin(cin_in), .sub(sub_in), .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0));
  chunk_serial_adder #(.WIDTH(16), .CHUNK(16)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_in[15:0]), .b(b_in[15:0]),
    .cin(cin_in), .sub(sub_in), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));
  chunk_serial_adder #(.WIDTH(32), .CHUNK(8)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_in), .b(b_in),
    .cin(cin_in), .sub(sub_in), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

  always_comb begin
    busy_m = busy0; done_m = done0; sum_m = {16'h0, sum0}; cout_m = cout0; ovf_m = ovf0;
    case (cur)
      1: begin busy_m = busy1; done_m = done1; sum_m = {16'h0, sum1}; cout_m = cout1; ovf_m = ovf1; end
      2: begin busy_m = busy2; done_m = done2; sum_m = sum2; cout_m = cout2; ovf_m = ovf2; end
      default: ;
    endcase
  end

  function automatic int width_of(input int cfg);
    return (cfg == 2) ? 32 : 16;
  endfunction

  function automatic int nch_of(input int cfg);
    return (cfg == 1) ? 1 : 4;
  endfunction

  // Reference: plain unsigned and signed arithmetic at the configured width.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sb);
    longint half, full, ua, ub, sa, sbv, ur, sr;
    res_t   r;
    half = longint'(1) << (w - 1);
    full = half * 2;
    ua   = longint'(a) & (full - 1);
    ub   = longint'(b) & (full - 1);
    sa   = (ua >= half) ? ua - full : ua;
    sbv  = (ub >= half) ? ub - full : ub;
    if (sb) begin
      ur     = ua - ub;
      r.cout = (ua >= ub);
      sr     = sa - sbv;
    end else begin
      ur     = ua + ub + longint'(ci);
      r.cout = (ur >= full);
      sr     = sa + sbv + longint'(ci);
    end
    r.sum = 32'(ur & (full - 1));
    r.ovf = (sr >= half) || (sr < -half);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one start pulse; returns at the negedge after the accepting edge.
  task automatic issue(input int cfg, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sb);
    @(negedge clk);
    cur = cfg; a_in = a; b_in = b; cin_in = ci; sub_in = sb;
    start_v[cfg] = 1'b1;
    @(negedge clk);
    start_v[cfg] = 1'b0;
  endtask

  task automatic wait_done(input int k0, output int lat, output int busy_n);
    lat = k0;
    busy_n = 0;
    while (!done_m && lat < 64) begin
      if (busy_m) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic directed(input string tag, input int cfg, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sb, input logic [31:0] es, input logic ec,
                          input logic eo);
    int lat, bn;
    issue(cfg, a, b, ci, sb);
    wait_done(1, lat, bn);
    check({tag, ".latency"}, lat, nch_of(cfg) + 1);
    check({tag, ".busy_cycles"}, bn, nch_of(cfg));
    check({tag, ".sum"}, sum_m, es);
    check({tag, ".cout"}, {31'h0, cout_m}, {31'h0, ec});
    check({tag, ".ovf"}, {31'h0, ovf_m}, {31'h0, eo});
  endtask

  initial begin
    int   lat, bn, extra;
    res_t exp;
    logic [31:0] ra, rb;
    logic rc, rs;

    // Reset, including start asserted together with reset.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    start_v[0] = 1'b1; a_in = 32'h1; b_in = 32'h1;
    @(negedge clk);
    check("rst_start.busy", {31'h0, busy0}, 32'h0);
    rst = 1'b0; start_v[0] = 1'b0;
    @(negedge clk);
    check("rst_start.busy_after", {31'h0, busy0}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      cur = c;
      #1;
      check($sformatf("reset%0d.busy", c), {31'h0, busy_m}, 32'h0);
      check($sformatf("reset%0d.done", c), {31'h0, done_m}, 32'h0);
      check($sformatf("reset%0d.sum", c), sum_m, 32'h0);
      check($sformatf("reset%0d.cout", c), {31'h0, cout_m}, 32'h0);
      check($sformatf("reset%0d.ovf", c), {31'h0, ovf_m}, 32'h0);
    end

    directed("add_basic", 0, 32'h1234, 32'h4321, 1'b0, 1'b0, 32'h5555, 1'b0, 1'b0);
    @(negedge clk);
    check("done_pulse_width", {31'h0, done_m}, 32'h0);
    directed("carry_chain", 0, 32'hFFFF, 32'h0000, 1'b1, 1'b0, 32'h0000, 1'b1, 1'b0);
    directed("add_ovf", 0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1);
    directed("sub_borrow", 0, 32'h0005, 32'h0007, 1'b1, 1'b1, 32'hFFFE, 1'b0, 1'b0);
    directed("sub_ovf", 0, 32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1);

    // A start pulse during RUN is ignored and not queued.
    issue(0, 32'h1234, 32'h4321, 1'b0, 1'b0);
    @(negedge clk);
    a_in = 32'h1; b_in = 32'h1; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(3, lat, bn);
    check("ignore_start.latency", lat, 5);
    check("ignore_start.sum", sum_m, 32'h5555);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_m || busy_m) extra++;
    end
    check("ignore_start.no_queue", extra, 0);

    // Start held high from RUN through DONE with new operands: accepted in DONE.
    issue(0, 32'h1234, 32'h4321, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a_in = 32'h0F0F; b_in = 32'h0101; start_v[0] = 1'b1;
    wait_done(3, lat, bn);
    check("b2b.first_latency", lat, 5);
    check("b2b.first_sum", sum_m, 32'h5555);
    check("b2b.busy_in_done", {31'h0, busy_m}, 32'h0);
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(1, lat, bn);
    check("b2b.second_spacing", lat, 5);
    check("b2b.second_sum", sum_m, 32'h1010);

    // Reset on the second RUN cycle aborts the operation with no done.
    issue(0, 32'h1111, 32'h2222, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort.busy", {31'h0, busy_m}, 32'h0);
    check("abort.done", {31'h0, done_m}, 32'h0);
    check("abort.sum", sum_m, 32'h0);
    check("abort.cout", {31'h0, cout_m}, 32'h0);
    check("abort.ovf", {31'h0, ovf_m}, 32'h0);
    rst = 1'b0;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_m) extra++;
    end
    check("abort.no_done", extra, 0);
    directed("after_abort", 0, 32'h0F00, 32'h00F0, 1'b1, 1'b0, 32'h0FF1, 1'b0, 1'b0);

    directed("single_chunk", 1, 32'hFFFF, 32'h0000, 1'b1, 1'b0, 32'h0000, 1'b1, 1'b0);
    directed("wide_sub", 2, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Random sweep per configuration.
    for (int c = 0; c < 3; c++) begin
      for (int n = 0; n < 1000; n++) begin
        ra = $urandom; rb = $urandom;
        rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
        if (width_of(c) == 16) begin
          ra[31:16] = '0; rb[31:16] = '0;
        end
        exp = model(width_of(c), ra, rb, rc, rs);
        issue(c, ra, rb, rc, rs);
        wait_done(1, lat, bn);
        check($sformatf("rand%0d.latency", c), lat, nch_of(c) + 1);
        check($sformatf("rand%0d.sum a=%0h b=%0h cin=%0b sub=%0b", c, ra, rb, rc, rs), sum_m, exp.sum);
        check($sformatf("rand%0d.cout", c), {31'h0, cout_m}, {31'h0, exp.cout});
        check($sformatf("rand%0d.ovf", c), {31'h0, ovf_m}, {31'h0, exp.ovf});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
